// File: rtl/vdc_bus_master_pkg.sv
// Shared definitions for the VDC bus master: bus widths, phase counter
// width, the transaction FSM state encoding and the counter load helper.
package vdc_bus_master_pkg;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } bus_state_e;

    // A phase of N CE ticks is counted as N-1 down to 0, so the terminal
    // count is reached on the last tick and the counter never wraps.
    function automatic logic [CNT_W-1:0] phase_load(input int cyc);
        return CNT_W'(cyc - 1);
    endfunction

endpackage

// File: rtl/vdc_bus_phase_cnt.sv
// Loadable 4-bit down-counter for the bus phases. A load takes effect on any
// clock edge (so a phase can start on an edge without CE); decrementing only
// happens on CE ticks and stops at zero. tc is registered alongside count.
module vdc_bus_phase_cnt
    import vdc_bus_master_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    logic [CNT_W-1:0] count_r;
    logic             tc_r;

    // Counter and terminal-count flag: load has priority over CE-gated decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
            tc_r    <= 1'b1;
        end else if (load) begin
            count_r <= load_val;
            tc_r    <= (load_val == {CNT_W{1'b0}});
        end else if (ce && (count_r != {CNT_W{1'b0}})) begin
            count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
            tc_r    <= (count_r == {{(CNT_W-1){1'b0}}, 1'b1});
        end else begin
            count_r <= count_r;
            tc_r    <= tc_r;
        end
    end

    assign tc = tc_r;

endmodule

// File: rtl/vdc_bus_master.sv
// Request/response front end driving the asynchronous VDC host bus
// (CSB/RDB/WRB strobes, 13-bit address, 8-bit split data bus). Each
// transaction walks SETUP -> STROBE -> HOLD, each phase timed in CE ticks.
// All bus outputs are registered from the next-state value so they change
// together with the state and never glitch.
module vdc_bus_master
    import vdc_bus_master_pkg::*;
#(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] a,
    output logic [DATA_W-1:0] db_o,
    output logic              db_oe,
    input  logic [DATA_W-1:0] db_i,
    output logic              rdb,
    output logic              wrb,
    output logic              csb
);

    localparam logic [CNT_W-1:0] SETUP_LD  = phase_load(SETUP_CYC);
    localparam logic [CNT_W-1:0] STROBE_LD = phase_load(STROBE_CYC);
    localparam logic [CNT_W-1:0] HOLD_LD   = phase_load(HOLD_CYC);

    bus_state_e        state_r;
    bus_state_e        state_nx_s;
    logic              accept_s;
    logic              wr_nx_s;
    logic              cnt_load_s;
    logic [CNT_W-1:0]  cnt_val_s;
    logic              phase_tc_s;
    logic              done_s;
    logic              capture_s;

    logic              wr_r;
    logic              req_ready_r;
    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_rdata_r;
    logic [DATA_W-1:0] rd_cap_r;
    logic [ADDR_W-1:0] a_r;
    logic [DATA_W-1:0] db_o_r;
    logic              db_oe_r;
    logic              rdb_r;
    logic              wrb_r;
    logic              csb_r;

    // Acceptance ignores CE; only the phase timing is CE-gated.
    assign accept_s = req_valid && req_ready_r;
    assign wr_nx_s  = accept_s ? req_wr : wr_r;

    vdc_bus_phase_cnt u_phase_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .ce       (ce),
        .load     (cnt_load_s),
        .load_val (cnt_val_s),
        .tc       (phase_tc_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic, phase counter loads, read capture and completion.
    always_comb begin
        state_nx_s = state_r;
        cnt_load_s = 1'b0;
        cnt_val_s  = {CNT_W{1'b0}};
        done_s     = 1'b0;
        capture_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nx_s = ST_SETUP;
                    cnt_load_s = 1'b1;
                    cnt_val_s  = SETUP_LD;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (ce && phase_tc_s) begin
                    state_nx_s = ST_STROBE;
                    cnt_load_s = 1'b1;
                    cnt_val_s  = STROBE_LD;
                end else begin
                    state_nx_s = ST_SETUP;
                end
            end
            ST_STROBE: begin
                if (ce && phase_tc_s) begin
                    state_nx_s = ST_HOLD;
                    cnt_load_s = 1'b1;
                    cnt_val_s  = HOLD_LD;
                    // DB_I is sampled only on the tick that closes the read strobe.
                    capture_s  = !wr_r;
                end else begin
                    state_nx_s = ST_STROBE;
                end
            end
            ST_HOLD: begin
                if (ce && phase_tc_s) begin
                    state_nx_s = ST_IDLE;
                    done_s     = 1'b1;
                end else begin
                    state_nx_s = ST_HOLD;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Bus strobes, output enable, ready and response pulse follow the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csb_r       <= 1'b1;
            rdb_r       <= 1'b1;
            wrb_r       <= 1'b1;
            db_oe_r     <= 1'b0;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
        end else begin
            csb_r       <= (state_nx_s == ST_IDLE);
            rdb_r       <= !((state_nx_s == ST_STROBE) && !wr_nx_s);
            wrb_r       <= !((state_nx_s == ST_STROBE) && wr_nx_s);
            db_oe_r     <= (state_nx_s != ST_IDLE) && wr_nx_s;
            req_ready_r <= (state_nx_s == ST_IDLE);
            rsp_valid_r <= done_s;
        end
    end

    // Request latch: address and direction on every acceptance, write data
    // only for writes so DB_O keeps the last written byte otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= {ADDR_W{1'b0}};
            wr_r   <= 1'b0;
            db_o_r <= {DATA_W{1'b0}};
        end else if (accept_s) begin
            a_r    <= req_addr;
            wr_r   <= req_wr;
            db_o_r <= req_wr ? req_wdata : db_o_r;
        end else begin
            a_r    <= a_r;
            wr_r   <= wr_r;
            db_o_r <= db_o_r;
        end
    end

    // Read data path: capture at end of strobe, publish at read completion
    // so RSP_RDATA only ever changes together with a read's RSP_VALID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cap_r    <= {DATA_W{1'b0}};
            rsp_rdata_r <= {DATA_W{1'b0}};
        end else begin
            rd_cap_r    <= capture_s ? db_i : rd_cap_r;
            rsp_rdata_r <= (done_s && !wr_r) ? rd_cap_r : rsp_rdata_r;
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign a         = a_r;
    assign db_o      = db_o_r;
    assign db_oe     = db_oe_r;
    assign rdb       = rdb_r;
    assign wrb       = wrb_r;
    assign csb       = csb_r;

endmodule

// File: doc/vdc_bus_master.md
VDC_BUS_MASTER -- requirements
Module: vdc_bus_master

Interface
REQ-001 Parameter SETUP_CYC, default 1, CE ticks with CSB low and address valid before the strobe falls; legal range 1..15.
REQ-002 Parameter STROBE_CYC, default 2, CE ticks with RDB or WRB low; legal range 1..15.
REQ-003 Parameter HOLD_CYC, default 1, CE ticks after the strobe rises with CSB, A and write data held; legal range 1..15.
REQ-004 CLK  in  1  single system clock; all state changes on the rising edge.
REQ-005 RESB  in  1  reset, asynchronous, active-low.
REQ-006 CE  in  1  clock enable; phase counters advance only on CLK edges with CE=1.
REQ-007 REQ_VALID  in  1  transaction request.
REQ-008 REQ_READY  out  1  block can accept a request.
REQ-009 REQ_WR  in  1  1=write, 0=read.
REQ-010 REQ_ADDR  in  13  VDC register/VRAM address.
REQ-011 REQ_WDATA  in  8  write data.
REQ-012 RSP_VALID  out  1  one-CLK pulse at transaction completion.
REQ-013 RSP_RDATA  out  8  read data, valid when RSP_VALID=1 after a read.
REQ-014 A  out  13  VDC address bus.
REQ-015 DB_O  out  8  data driven to the VDC.
REQ-016 DB_OE  out  1  DB_O valid (write transaction in progress).
REQ-017 DB_I  in  8  data returned by the VDC.
REQ-018 RDB, WRB, CSB  out  1 each  active-low read strobe, write strobe, chip select.

Function
REQ-019 FSM states: IDLE, SETUP, STROBE, HOLD; REQ_READY=1 only in IDLE.
REQ-020 Acceptance occurs on any CLK edge with REQ_VALID=1 and REQ_READY=1, regardless of CE; REQ_ADDR, REQ_WR and REQ_WDATA are latched and IDLE->SETUP.
REQ-021 SETUP: CSB=0, A=latched address, RDB=WRB=1; after SETUP_CYC CE ticks -> STROBE.
REQ-022 STROBE: CSB=0; RDB=0 for a read or WRB=0 for a write; after STROBE_CYC CE ticks -> HOLD.
REQ-023 Read data: DB_I is captured on the CE tick that ends STROBE; it is not captured at any other point.
REQ-024 HOLD: RDB=WRB=1, CSB=0, A and DB_O unchanged; after HOLD_CYC CE ticks -> IDLE with RSP_VALID=1 for exactly one CLK.
REQ-025 DB_OE=1 from SETUP through HOLD for writes; it is 0 otherwise, and DB_O=latched data whenever DB_OE=1.
REQ-026 RSP_RDATA holds its last captured value until the next read completes; writes leave it unchanged.
REQ-027 A transaction occupies exactly SETUP_CYC+STROBE_CYC+HOLD_CYC CE ticks from acceptance to RSP_VALID.
REQ-028 With CE held at 0, the FSM and all bus outputs hold indefinitely.
REQ-029 RDB and WRB are never low simultaneously, and neither is low while CSB=1.
REQ-030 In IDLE: CSB=RDB=WRB=1 and DB_OE=0; A and DB_O retain their last values.
REQ-031 The earliest next acceptance is the CLK edge after RSP_VALID; there are no back-to-back strobes without passing through IDLE.
REQ-032 Phase counters are 4 bits, load parameter-1 on phase entry, and wrap is impossible.

Reset
REQ-033 RESB=0 forces, asynchronously: state IDLE, CSB=RDB=WRB=1, DB_OE=0, A=0, DB_O=0, RSP_VALID=0, RSP_RDATA=0, counters=0.
REQ-034 Reset asserted mid-transaction aborts it with no RSP_VALID; REQ_READY=1 on the first edge after release.

Structure
REQ-035 The shared package holds the FSM state enum and the bus width constants (address 13, data 8).
REQ-036 One sub-module, vdc_bus_phase_cnt: a loadable down-counter gated by CE with a terminal-count output.

Verification
REQ-037 Defaults, CE=1, write 0x1A5 <- 0x3C: CSB low for 4 CLK, WRB low for CLK 2-3, DB_OE=1 for 4 CLK, RSP_VALID on the 5th edge, and the VDC register updates.
REQ-038 Read 0x1A5 after the REQ-037 write: RDB low for 2 CLK, RSP_RDATA=0x3C with RSP_VALID, and DB_OE stays 0.
REQ-039 CE=1 every 3rd CLK, SETUP/STROBE/HOLD=2/3/1: RSP_VALID occurs 6 CE ticks after acceptance, and the strobes hold between ticks.
REQ-040 REQ_VALID held high for 3 requests: each is accepted only in IDLE, there are 3 RSP_VALID pulses, and REQ_READY=0 during each transaction.
REQ-041 RESB pulsed low during STROBE of a write: WRB and CSB go to 1 immediately, there is no RSP_VALID, and a following read succeeds.
REQ-042 Every bench runs an assertion monitor checking REQ-029 and REQ-025 on every cycle.
